// File: rtl/nonce_result_scanner.sv
// Scans NUM_NONCES hash result words for the minimum and the count below target,
// then writes a three-word summary back through the shared single-port memory.
module nonce_result_scanner #(
  parameter int NUM_NONCES = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [15:0]                         result_addr,
  input  logic [15:0]                         summary_addr,
  input  logic [31:0]                         target,
  output logic                                done,
  output logic                                found,
  output logic [31:0]                         best_nonce,
  output logic [31:0]                         best_hash,
  output logic [$clog2(NUM_NONCES+1)-1:0]     match_count,
  output logic                                mem_clk,
  output logic                                mem_we,
  output logic [15:0]                         mem_addr,
  output logic [31:0]                         mem_write_data,
  input  logic [31:0]                         mem_read_data
);

  localparam int CW = $clog2(NUM_NONCES + 1);
  localparam int TW = $clog2(NUM_NONCES + 6);
  localparam logic [TW-1:0] LAST_ISSUE = TW'(NUM_NONCES - 1);
  localparam logic [TW-1:0] FIRST_CAP  = TW'(2);
  localparam logic [TW-1:0] LAST_CAP   = TW'(NUM_NONCES + 1);
  localparam logic [TW-1:0] WR_NONCE   = TW'(NUM_NONCES + 2);
  localparam logic [TW-1:0] WR_HASH    = TW'(NUM_NONCES + 3);
  localparam logic [TW-1:0] WR_SUMMARY = TW'(NUM_NONCES + 4);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [31:0] pack_summary(input logic f, input logic [CW-1:0] c);
    return {f, 15'b0, 16'(c)};
  endfunction

  state_t          state_r, state_s;
  logic [TW-1:0]   cyc_r, cyc_s;
  logic [15:0]     res_base_r, res_base_s;
  logic [15:0]     sum_base_r, sum_base_s;
  logic [31:0]     target_r, target_s;
  logic            done_r, done_s;
  logic            found_r, found_s;
  logic [31:0]     best_nonce_r, best_nonce_s;
  logic [31:0]     best_hash_r, best_hash_s;
  logic [CW-1:0]   count_r, count_s;
  logic            mem_we_r, mem_we_s;
  logic [15:0]     mem_addr_r, mem_addr_s;
  logic [31:0]     mem_wdata_r, mem_wdata_s;

  assign mem_clk        = clk;
  assign done           = done_r;
  assign found          = found_r;
  assign best_nonce     = best_nonce_r;
  assign best_hash      = best_hash_r;
  assign match_count    = count_r;
  assign mem_we         = mem_we_r;
  assign mem_addr       = mem_addr_r;
  assign mem_write_data = mem_wdata_r;

  // State and output registers; cyc_r counts edges since the start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_IDLE;
      cyc_r        <= '0;
      res_base_r   <= 16'd0;
      sum_base_r   <= 16'd0;
      target_r     <= 32'd0;
      done_r       <= 1'b0;
      found_r      <= 1'b0;
      best_nonce_r <= 32'd0;
      best_hash_r  <= 32'd0;
      count_r      <= '0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= 16'd0;
      mem_wdata_r  <= 32'd0;
    end else begin
      state_r      <= state_s;
      cyc_r        <= cyc_s;
      res_base_r   <= res_base_s;
      sum_base_r   <= sum_base_s;
      target_r     <= target_s;
      done_r       <= done_s;
      found_r      <= found_s;
      best_nonce_r <= best_nonce_s;
      best_hash_r  <= best_hash_s;
      count_r      <= count_s;
      mem_we_r     <= mem_we_s;
      mem_addr_r   <= mem_addr_s;
      mem_wdata_r  <= mem_wdata_s;
    end
  end

  // Next-state and next-output computation.
  always_comb begin
    state_s      = state_r;
    cyc_s        = cyc_r;
    res_base_s   = res_base_r;
    sum_base_s   = sum_base_r;
    target_s     = target_r;
    done_s       = done_r;
    found_s      = found_r;
    best_nonce_s = best_nonce_r;
    best_hash_s  = best_hash_r;
    count_s      = count_r;
    mem_we_s     = 1'b0;
    mem_addr_s   = mem_addr_r;
    mem_wdata_s  = mem_wdata_r;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_s      = S_READ;
          cyc_s        = TW'(1);
          res_base_s   = result_addr;
          sum_base_s   = summary_addr;
          target_s     = target;
          done_s       = 1'b0;
          found_s      = 1'b0;
          best_nonce_s = 32'd0;
          best_hash_s  = 32'hFFFF_FFFF;
          count_s      = '0;
          mem_addr_s   = result_addr;
        end else begin
          state_s = state_r;
        end
      end
      S_READ: begin
        cyc_s = cyc_r + TW'(1);
        if (cyc_r <= LAST_ISSUE) begin
          mem_addr_s = res_base_r + 16'(cyc_r);
        end else begin
          mem_addr_s = mem_addr_r;
        end
        // Strict compares: equal hashes keep the earlier nonce.
        if (cyc_r >= FIRST_CAP && mem_read_data < best_hash_r) begin
          best_hash_s  = mem_read_data;
          best_nonce_s = 32'(cyc_r) - 32'd2;
        end else begin
          best_hash_s = best_hash_r;
        end
        if (cyc_r >= FIRST_CAP && mem_read_data < target_r) begin
          count_s = count_r + CW'(1);
          found_s = 1'b1;
        end else begin
          count_s = count_r;
        end
        if (cyc_r == LAST_CAP) begin
          state_s = S_WRITE;
        end else begin
          state_s = S_READ;
        end
      end
      S_WRITE: begin
        cyc_s = cyc_r + TW'(1);
        if (cyc_r == WR_NONCE) begin
          mem_we_s    = 1'b1;
          mem_addr_s  = sum_base_r;
          mem_wdata_s = best_nonce_r;
        end else if (cyc_r == WR_HASH) begin
          mem_we_s    = 1'b1;
          mem_addr_s  = sum_base_r + 16'd1;
          mem_wdata_s = best_hash_r;
        end else if (cyc_r == WR_SUMMARY) begin
          mem_we_s    = 1'b1;
          mem_addr_s  = sum_base_r + 16'd2;
          mem_wdata_s = pack_summary(found_r, count_r);
        end else begin
          cyc_s   = cyc_r;
          done_s  = 1'b1;
          state_s = S_DONE;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_nonce_result_scanner.sv
// Scoreboard bench: stimulus queues expected scan results and summary writes,
// a negedge monitor compares them when the scanner writes or raises done.
module tb_nonce_result_scanner;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] result_addr = 16'd0;
  logic [15:0] summary_addr = 16'd0;
  logic [31:0] target = 32'd0;
  logic        done, found, mem_clk, mem_we;
  logic [31:0] best_nonce, best_hash, mem_write_data, mem_read_data;
  logic [4:0]  match_count;
  logic [15:0] mem_addr;

  nonce_result_scanner #(.NUM_NONCES(N)) dut (
    .clk(clk), .reset(reset), .start(start), .result_addr(result_addr),
    .summary_addr(summary_addr), .target(target), .done(done), .found(found),
    .best_nonce(best_nonce), .best_hash(best_hash), .match_count(match_count),
    .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Memory: address registered at edge E is returned for sampling at edge E+2.
  logic [31:0] mem [0:65535];
  logic [31:0] rd_q = 32'd0;
  always @(posedge clk) rd_q <= mem[mem_addr];
  assign mem_read_data = rd_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] nonce;
    logic [31:0] hash;
    logic [31:0] cnt;
    logic        fnd;
    int          c0;
  } exp_t;
  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wr_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   zero_at = -1;
  int   low_at = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  logic done_q = 1'b0;
  int   wait_cnt = 0;
  exp_t e;
  wr_t  w;

  // Monitor: all comparisons happen here, on the falling edge.
  always @(negedge clk) begin
    if (done && !done_q) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("best_nonce", best_nonce, e.nonce);
        check("best_hash", best_hash, e.hash);
        check("match_count", 32'(match_count), e.cnt);
        check("found", 32'(found), 32'(e.fnd));
        check("done_latency", 32'(cyc - e.c0), 32'd21);
        check("writes_pending", 32'(wr_q.size()), 32'd0);
        wait_cnt = 0;
      end
    end
    if (mem_we) begin
      if (wr_q.size() == 0) begin
        check("unexpected_write", 32'(mem_we), 32'd0);
      end else begin
        w = wr_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(w.a));
        check("wr_data", mem_write_data, w.d);
      end
    end
    if (cyc == zero_at) begin
      check("rst_done", 32'(done), 32'd0);
      check("rst_found", 32'(found), 32'd0);
      check("rst_best_nonce", best_nonce, 32'd0);
      check("rst_best_hash", best_hash, 32'd0);
      check("rst_match_count", 32'(match_count), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", mem_write_data, 32'd0);
    end
    if (cyc == low_at) check("done_drop_on_start", 32'(done), 32'd0);
    if (exp_q.size() != 0) begin
      wait_cnt++;
      if (wait_cnt > 40) begin
        check("done_timeout", 32'(done), 32'd1);
        e = exp_q.pop_front();
        wait_cnt = 0;
      end
    end
    done_q = done;
  end

  logic [31:0] words[$];

  // Reference: minimum word, its first index, and how many are strictly below target.
  task automatic run_scan(input logic [15:0] rb, input logic [15:0] sb, input logic [31:0] tg,
                          input bit pulses, input bit abort);
    exp_t        x;
    wr_t         y;
    logic [31:0] mn[$];
    int          idx[$];
    int          c;
    for (int i = 0; i < N; i++) mem[16'(rb + 16'(i))] = words[i];
    mn  = words.min();
    idx = words.find_first_index(v) with (v == mn[0]);
    c   = words.sum() with (int'(item < tg));
    x.nonce = 32'(idx[0]);
    x.hash  = mn[0];
    x.cnt   = 32'(c);
    x.fnd   = (c > 0);
    @(negedge clk);
    result_addr = rb; summary_addr = sb; target = tg; start = 1'b1;
    low_at = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    x.c0 = cyc;
    if (abort) begin
      repeat (7) @(negedge clk);
      reset = 1'b1;
      zero_at = cyc + 1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      return;
    end
    exp_q.push_back(x);
    y.a = sb;          y.d = x.nonce;                           wr_q.push_back(y);
    y.a = sb + 16'd1;  y.d = x.hash;                            wr_q.push_back(y);
    y.a = sb + 16'd2;  y.d = {x.fnd, 15'b0, 16'(c)};            wr_q.push_back(y);
    if (pulses) begin
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (13) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int k = 0; k < 80 && exp_q.size() != 0; k++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic fill_random();
    words.delete();
    for (int i = 0; i < N; i++) words.push_back($urandom);
  endtask

  task automatic fill_const(input logic [31:0] v);
    words.delete();
    for (int i = 0; i < N; i++) words.push_back(v);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    zero_at = 2;
    repeat (4) @(negedge clk);
    reset = 1'b0;

    words.delete();
    for (int i = 0; i < N; i++) words.push_back(32'h1000_0000 - 32'(i));
    run_scan(16'h0100, 16'h0800, 32'h0FFF_FFF8, 1'b0, 1'b0);

    fill_const(32'h5555_5555);
    run_scan(16'h0200, 16'h0900, 32'h5555_5555, 1'b0, 1'b0);

    fill_random();
    run_scan(16'hFFF8, 16'hFFFE, $urandom, 1'b0, 1'b0);

    fill_random();
    run_scan(16'h0300, 16'h0A00, 32'h8000_0000, 1'b0, 1'b1);
    fill_random();
    run_scan(16'h0300, 16'h0A00, 32'h8000_0000, 1'b0, 1'b0);

    fill_random();
    run_scan(16'h0400, 16'h0B00, 32'h4000_0000, 1'b1, 1'b0);
    run_scan(16'h0400, 16'h0B00, 32'hFFFF_FFFF, 1'b0, 1'b0);

    fill_random();
    run_scan(16'h0500, 16'h0C00, 32'h0000_0000, 1'b0, 1'b0);

    fill_const(32'hFFFF_FFFF);
    run_scan(16'h0600, 16'h0D00, 32'hFFFF_FFFF, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      fill_random();
      words[$urandom_range(N-1, 0)] = words[$urandom_range(N-1, 0)];
      run_scan(16'($urandom), 16'($urandom), words[$urandom_range(N-1, 0)], r[0], 1'b0);
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
